// File: rtl/mlp_neuron_engine_if.sv
// Bundles the MLP engine's handshake, weight-write and command signals.
// master: the controller/consumer side; slave: the engine side.
interface mlp_neuron_engine_if #(
    parameter int unsigned M  = 3,
    parameter int unsigned N  = 2,
    parameter int unsigned DW = 8
);
    localparam int unsigned WAW = $clog2((M-1)*N*(N+1));
    localparam int unsigned LW  = $clog2(M-1);
    localparam int unsigned NW  = $clog2(N);

    logic            in_valid;
    logic            in_ready;
    logic [N*DW-1:0] in_data;
    logic            w_we;
    logic [WAW-1:0]  w_addr;
    logic [DW-1:0]   w_data;
    logic            read_en;
    logic            write_en;
    logic [LW-1:0]   layer_addr;
    logic [NW-1:0]   neuron_addr;
    logic            done_in;
    logic            out_valid;
    logic            out_ready;
    logic [N*DW-1:0] out_data;
    logic            err;

    modport master (
        output in_valid, in_data, w_we, w_addr, w_data, read_en, write_en,
               layer_addr, neuron_addr, done_in, out_ready,
        input  in_ready, out_valid, out_data, err
    );

    modport slave (
        input  in_valid, in_data, w_we, w_addr, w_data, read_en, write_en,
               layer_addr, neuron_addr, done_in, out_ready,
        output in_ready, out_valid, out_data, err
    );
endinterface

// File: rtl/mlp_neuron_engine.sv
// Fully-connected MLP neuron engine: holds per-layer activations and
// weights/biases, evaluates one neuron per controller command with
// zero-cycle latency (fixed-point MAC, ReLU, saturation) and presents the
// last layer as the result vector.
// Ports: clk, rst (sync, active-high), bus (slave side of mlp_neuron_engine_if:
// input handshake, weight writes, read/write commands, done, output handshake, err).
module mlp_neuron_engine #(
    parameter int unsigned M    = 3,
    parameter int unsigned N    = 2,
    parameter int unsigned DW   = 8,
    parameter int unsigned FRAC = 4
) (
    input logic               clk,
    input logic               rst,
    mlp_neuron_engine_if.slave bus
);
    localparam int unsigned WN   = (M-1)*N*(N+1);
    localparam int unsigned WAW  = $clog2(WN);
    localparam int unsigned AW   = 2*DW + $clog2(N+1);
    localparam int unsigned LW   = $clog2(M-1);
    localparam int unsigned LIW  = $clog2(M);
    localparam int unsigned NW   = $clog2(N);
    localparam int unsigned MAXV = 2**(DW-1) - 1;

    typedef enum logic [1:0] {LOAD, RUN, HOLD} state_t;

    state_t                 state_q, state_d;
    logic signed [DW-1:0]   act_q [M][N];
    logic signed [DW-1:0]   act_d [M][N];
    logic signed [DW-1:0]   wgt_q [WN];
    logic                   err_q, err_d;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic [N*DW-1:0]        out_data_q, out_data_d;
    logic                   cmd_ok;
    logic [WAW-1:0]         base;
    logic signed [AW-1:0]   acc, shifted;
    logic signed [DW-1:0]   res;
    logic                   w_ok;

    assign w_ok = bus.w_we && (32'(bus.w_addr) < WN);

    // Next state, command evaluation, error detection and output staging.
    always_comb begin
        state_d    = state_q;
        act_d      = act_q;
        err_d      = err_q;
        out_data_d = '0;
        cmd_ok     = 1'b0;
        base       = '0;
        acc        = '0;
        shifted    = '0;
        res        = '0;

        if (bus.read_en != bus.write_en) begin
            err_d = 1'b1;
        end else if (bus.read_en) begin
            if (state_q != RUN || bus.layer_addr > LW'(M-2) ||
                32'(bus.neuron_addr) > N-1) begin
                err_d = 1'b1;
            end else begin
                cmd_ok = 1'b1;
            end
        end

        if (bus.w_we && !w_ok) begin
            err_d = 1'b1;
        end

        // MAC reads registered weights, so a same-cycle weight write is not seen.
        if (cmd_ok) begin
            base = WAW'((32'(bus.layer_addr)*N + 32'(bus.neuron_addr))*(N+1));
            acc  = AW'(wgt_q[base + WAW'(N)]) <<< FRAC;
            for (int k = 0; k < N; k++) begin
                acc = acc + AW'(act_q[LIW'(bus.layer_addr)][NW'(k)]) *
                            AW'(wgt_q[base + WAW'(k)]);
            end
            shifted = acc >>> FRAC;
            if (shifted < 0) begin
                res = '0;
            end else if (shifted > $signed(AW'(MAXV))) begin
                res = DW'(MAXV);
            end else begin
                res = DW'(shifted);
            end
            act_d[LIW'(32'(bus.layer_addr) + 1)][bus.neuron_addr] = res;
        end

        case (state_q)
            LOAD: begin
                if (bus.in_valid && in_ready_q) begin
                    for (int k = 0; k < N; k++) begin
                        act_d[0][NW'(k)] = bus.in_data[k*DW +: DW];
                    end
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.done_in) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_valid_q && bus.out_ready) begin
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase

        // Result includes a command completing in the same cycle as done_in.
        if (state_d == HOLD) begin
            for (int k = 0; k < N; k++) begin
                out_data_d[k*DW +: DW] = act_d[M-1][NW'(k)];
            end
        end
    end

    // State and storage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD;
            act_q       <= '{default: '0};
            wgt_q       <= '{default: '0};
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            act_q       <= act_d;
            err_q       <= err_d;
            in_ready_q  <= (state_d == LOAD);
            out_valid_q <= (state_d == HOLD);
            out_data_q  <= out_data_d;
            if (w_ok) begin
                wgt_q[bus.w_addr] <= bus.w_data;
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_mlp_neuron_engine.sv
// Self-checking bench for mlp_neuron_engine: directed scenarios plus random
// weights/inputs/commands checked against an integer-arithmetic MLP model.
module tb_mlp_neuron_engine;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mlp_neuron_engine_if #(.M(3), .N(2), .DW(8)) b0 ();
    mlp_neuron_engine_if #(.M(3), .N(3), .DW(8)) b1 ();

    mlp_neuron_engine #(.M(3), .N(2), .DW(8), .FRAC(4)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
    mlp_neuron_engine #(.M(3), .N(3), .DW(8), .FRAC(4)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));

    int errors = 0;
    int checks = 0;

    // Reference model of the N=2 instance.
    int mw [12];
    int ma [3][2];
    bit merr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        foreach (mw[i]) mw[i] = 0;
        foreach (ma[i, j]) ma[i][j] = 0;
        merr = 1'b0;
    endtask

    // Neuron output: weighted sum plus bias in Q.FRAC, floor-rescale, ReLU, clamp.
    function automatic int neuron(input int l, input int n);
        int base = (l*2 + n)*3;
        int acc  = mw[base + 2] * 16;
        for (int k = 0; k < 2; k++) acc += ma[l][k] * mw[base + k];
        acc = acc >>> 4;
        if (acc < 0) return 0;
        if (acc > 127) return 127;
        return acc;
    endfunction

    function automatic logic [15:0] exp_out0();
        return {8'(ma[2][1]), 8'(ma[2][0])};
    endfunction

    function automatic int rnd8();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    task automatic wr0(input int a, input int d);
        b0.w_we = 1'b1; b0.w_addr = 4'(a); b0.w_data = 8'(d);
        tick();
        b0.w_we = 1'b0;
        if (a < 12) mw[a] = d; else merr = 1'b1;
    endtask

    task automatic cmd0(input int l, input int n, input bit wr = 1'b0,
                        input int wa = 0, input int wd = 0);
        b0.read_en = 1'b1; b0.write_en = 1'b1;
        b0.layer_addr = 1'(l); b0.neuron_addr = 1'(n);
        if (wr) begin b0.w_we = 1'b1; b0.w_addr = 4'(wa); b0.w_data = 8'(wd); end
        tick();
        b0.read_en = 1'b0; b0.write_en = 1'b0; b0.w_we = 1'b0;
        ma[l+1][n] = neuron(l, n);
        if (wr) mw[wa] = wd;
    endtask

    task automatic all_cmds0();
        cmd0(0, 0); cmd0(0, 1); cmd0(1, 0); cmd0(1, 1);
    endtask

    task automatic load0(input int a0, input int a1);
        b0.in_valid = 1'b1; b0.in_data = {8'(a1), 8'(a0)};
        tick();
        b0.in_valid = 1'b0;
        ma[0][0] = a0; ma[0][1] = a1;
        chk("load_in_ready", 32'(b0.in_ready), 32'd0);
    endtask

    task automatic done0();
        b0.done_in = 1'b1;
        tick();
        b0.done_in = 1'b0;
        chk("done_out_valid", 32'(b0.out_valid), 32'd1);
        chk("done_out_data", 32'(b0.out_data), 32'(exp_out0()));
        chk("done_err", 32'(b0.err), 32'(merr));
    endtask

    task automatic consume0();
        b0.out_ready = 1'b1;
        tick();
        b0.out_ready = 1'b0;
        chk("consume_in_ready", 32'(b0.in_ready), 32'd1);
        chk("consume_out_valid", 32'(b0.out_valid), 32'd0);
        chk("consume_out_data", 32'(b0.out_data), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        b0.in_valid = 0; b0.in_data = '0; b0.w_we = 0; b0.w_addr = '0; b0.w_data = '0;
        b0.read_en = 0; b0.write_en = 0; b0.layer_addr = '0; b0.neuron_addr = '0;
        b0.done_in = 0; b0.out_ready = 0;
        b1.in_valid = 0; b1.in_data = '0; b1.w_we = 0; b1.w_addr = '0; b1.w_data = '0;
        b1.read_en = 0; b1.write_en = 0; b1.layer_addr = '0; b1.neuron_addr = '0;
        b1.done_in = 0; b1.out_ready = 0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        model_reset();

        // Reset state
        chk("rst_in_ready", 32'(b0.in_ready), 32'd1);
        chk("rst_out_valid", 32'(b0.out_valid), 32'd0);
        chk("rst_out_data", 32'(b0.out_data), 32'd0);
        chk("rst_err", 32'(b0.err), 32'd0);
        chk("rst_in_ready_n3", 32'(b1.in_ready), 32'd1);

        // done_in outside RUN is harmless
        b0.done_in = 1'b1; tick(); b0.done_in = 1'b0;
        chk("done_load_err", 32'(b0.err), 32'd0);
        chk("done_load_in_ready", 32'(b0.in_ready), 32'd1);

        // Basic inference
        for (int a = 0; a < 12; a++) wr0(a, (a % 3 == 2) ? 0 : 16);
        load0(16, 16);
        all_cmds0();
        done0();
        chk("basic_out", 32'(b0.out_data), 32'h4040);

        // Output backpressure
        repeat (5) begin
            tick();
            chk("bp_out_valid", 32'(b0.out_valid), 32'd1);
            chk("bp_out_data", 32'(b0.out_data), 32'(exp_out0()));
        end
        consume0();

        // ReLU
        wr0(2, -80);
        load0(16, 16);
        all_cmds0();
        done0();
        chk("relu_out", 32'(b0.out_data), 32'h2020);
        consume0();

        // Saturation
        wr0(2, 0);
        for (int a = 0; a < 12; a++) if (a % 3 != 2) wr0(a, 112);
        load0(112, 112);
        all_cmds0();
        done0();
        chk("sat_out", 32'(b0.out_data), 32'h7F7F);
        consume0();

        // Command coinciding with a write to one of its weights
        load0(16, 16);
        cmd0(0, 0, 1'b1, 0, -3);
        cmd0(0, 1); cmd0(1, 0); cmd0(1, 1);
        done0();
        consume0();

        // Random weights, inputs and command orders
        repeat (4) begin
            for (int a = 0; a < 12; a++) wr0(a, rnd8());
            load0(rnd8(), rnd8());
            repeat (6) cmd0(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
            done0();
            consume0();
        end

        // Reset mid-RUN abandons the run and clears activations
        load0(rnd8(), rnd8());
        cmd0(0, 0);
        cmd0(1, 0);
        do_reset();
        chk("midrun_in_ready", 32'(b0.in_ready), 32'd1);
        chk("midrun_out_valid", 32'(b0.out_valid), 32'd0);
        chk("midrun_out_data", 32'(b0.out_data), 32'd0);
        chk("midrun_err", 32'(b0.err), 32'd0);
        load0(5, 5);
        done0();
        consume0();

        // Mismatched strobes
        b0.read_en = 1'b1; tick(); b0.read_en = 1'b0;
        chk("strobe_err", 32'(b0.err), 32'd1);
        tick();
        chk("err_sticky", 32'(b0.err), 32'd1);

        // Command outside RUN
        do_reset();
        b0.read_en = 1'b1; b0.write_en = 1'b1; tick();
        b0.read_en = 1'b0; b0.write_en = 1'b0;
        chk("cmd_load_err", 32'(b0.err), 32'd1);
        chk("cmd_load_in_ready", 32'(b0.in_ready), 32'd1);

        // Out-of-range weight address
        do_reset();
        wr0(13, 7);
        chk("waddr_err", 32'(b0.err), 32'(merr));

        // N=3: neuron_addr=3 is rejected and leaves act untouched
        for (int a = 0; a < 24; a++) begin
            b1.w_we = 1'b1; b1.w_addr = 5'(a); b1.w_data = 8'd16;
            tick();
        end
        b1.w_we = 1'b0;
        b1.in_valid = 1'b1; b1.in_data = 24'h101010; tick(); b1.in_valid = 1'b0;
        b1.read_en = 1'b1; b1.write_en = 1'b1; b1.layer_addr = 1'b0; b1.neuron_addr = 2'd3;
        tick();
        chk("n3_bad_neuron_err", 32'(b1.err), 32'd1);
        b1.layer_addr = 1'b1;
        for (int n = 0; n < 3; n++) begin
            b1.neuron_addr = 2'(n);
            tick();
        end
        b1.read_en = 1'b0; b1.write_en = 1'b0;
        b1.done_in = 1'b1; tick(); b1.done_in = 1'b0;
        chk("n3_out_valid", 32'(b1.out_valid), 32'd1);
        chk("n3_out_data", 32'(b1.out_data), 32'h101010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mlp_neuron_engine.md
MLP_NEURON_ENGINE -- requirements
Module: mlp_neuron_engine

Interface
REQ-001 SHALL have parameter M, default 3: layer count including the input layer; legal values are M>=3.
REQ-002 SHALL have parameter N, default 2: neurons per layer; legal values are N>=2.
REQ-003 SHALL have parameter DW, default 8: signed two's-complement data/weight width.
REQ-004 SHALL have parameter FRAC, default 4: number of fractional bits in DW values.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port in_valid, input, 1 bit: an input vector is offered.
REQ-008 SHALL have port in_ready, output, 1 bit: the engine accepts an input vector.
REQ-009 SHALL have port in_data, input, N*DW bits: input activations; neuron k occupies bits [k*DW +: DW].
REQ-010 SHALL have port w_we, input, 1 bit: weight/bias write strobe.
REQ-011 SHALL have port w_addr, input, $clog2((M-1)*N*(N+1)) bits: index = (layer*N + neuron)*(N+1) + k; k=N selects the bias.
REQ-012 SHALL have port w_data, input, DW bits: the weight or bias value to write.
REQ-013 SHALL have port read_en, input, 1 bit: command read strobe from the MLP controller.
REQ-014 SHALL have port write_en, input, 1 bit: command write strobe from the MLP controller.
REQ-015 SHALL have port layer_addr, input, $clog2(M-1) bits: source layer of the command.
REQ-016 SHALL have port neuron_addr, input, $clog2(N) bits: destination neuron of the command.
REQ-017 SHALL have port done_in, input, 1 bit: controller end-of-run pulse.
REQ-018 SHALL have port out_valid, output, 1 bit: the result vector is valid.
REQ-019 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-020 SHALL have port out_data, output, N*DW bits: last-layer activations, packed as in_data.
REQ-021 SHALL have port err, output, 1 bit: sticky error flag.

Function
REQ-022 SHALL hold storage act[0..M-1][0..N-1] (DW each) and weight registers wgt[(M-1)*N*(N+1)] (DW each).
REQ-023 SHALL implement states LOAD, RUN and HOLD; the reset state is LOAD.
REQ-024 SHALL drive in_ready = 1 only in LOAD; on in_valid&&in_ready, act[0] <= in_data and the state moves to RUN.
REQ-025 SHALL, in RUN, treat a cycle with read_en&&write_en as a command with l = layer_addr and n = neuron_addr.
REQ-026 SHALL compute, for each command, acc = sum over k of act[l][k]*wgt[l][n][k] + (bias << FRAC).
REQ-027 SHALL size acc at 2*DW + $clog2(N+1) bits, signed, with no intermediate overflow.
REQ-028 SHALL form the result as acc >>> FRAC, then apply ReLU (negative -> 0), then saturate to 2^(DW-1)-1.
REQ-029 SHALL write the result to act[l+1][n] at the end of the same cycle, giving zero-cycle latency.
REQ-030 SHALL make a command in the following cycle see the updated value of act[l+1][n].
REQ-031 SHALL sustain one command per cycle with no stall.
REQ-032 SHALL ignore a command with l>M-2 or n>N-1 and set err.
REQ-033 SHALL set err and perform no write when read_en != write_en in any state.
REQ-034 SHALL ignore a command outside RUN and set err.
REQ-035 SHALL move RUN -> HOLD on done_in; a command in the same cycle SHALL complete first.
REQ-036 SHALL ignore done_in outside RUN with no error.
REQ-037 SHALL drive out_valid = 1 in HOLD and out_data = act[M-1], held stable until out_valid&&out_ready, then move HOLD -> LOAD.
REQ-038 SHALL drive out_data to all-zero outside HOLD.
REQ-039 SHALL accept w_we in every state and write wgt[w_addr] <= w_data.
REQ-040 SHALL use the old weight value in a command that coincides with a write to the same entry.
REQ-041 SHALL ignore a write with w_addr >= (M-1)*N*(N+1) and set err.
REQ-042 SHALL clear err only by rst.

Reset
REQ-043 SHALL, when rst=1, force state=LOAD, all act=0, all wgt=0, err=0, out_valid=0, out_data=0 and in_ready=1 on the next edge.
REQ-044 SHALL abandon any run when rst is asserted mid-RUN or mid-HOLD, with no partial output.

Verification
REQ-045 SHALL cover basic inference: M=3, N=2, DW=8, FRAC=4, all weights 16, biases 0, in_data={16,16}, commands (0,0)(0,1)(1,0)(1,1), done_in -> out_valid=1 and out_data={64,64}.
REQ-046 SHALL cover ReLU: as REQ-045 with bias[0][0]=-80 -> act[1][0]=0 and out_data={32,32}.
REQ-047 SHALL cover saturation: weights 112, in_data={112,112} -> out_data={127,127}.
REQ-048 SHALL cover output backpressure: out_ready=0 for 5 cycles -> out_valid and out_data stable; out_ready=1 -> LOAD next cycle with in_ready=1.
REQ-049 SHALL cover errors: N=3 with neuron_addr=3 -> err=1 and no act change; read_en=1 with write_en=0 -> err=1.
REQ-050 SHALL cover reset mid-RUN: rst=1 after 2 commands -> next cycle state LOAD, act all 0, out_valid=0.
